inst_mem_loader: RTL and testbench

- Boot-time stage directly upstream of the single-cycle MIPS datapath. It replaces file preloading of instruction memory with hardware loading.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instructions. Writes them sequentially into the instruction memory write port.
- Holds the CPU stalled until the program is complete, then releases it with a one-cycle CPU reset pulse so the PC starts at word 0.

---
 rtl/inst_mem_loader_if.sv | 35 +++
 rtl/inst_mem_loader.sv | 185 ++++++++++++++++++
 tb/tb_inst_mem_loader.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_mem_loader_if.sv
// Boot-loader bus bundle: the byte-stream handshake into the loader and the
// instruction-memory write port out of it.
// The slave modport is the loader's view. The master modport is the view of
// the surrounding system: it sources the byte stream and sinks the memory writes.
interface inst_mem_loader_if #(
    parameter int ADDR_W = 8
) ();
    // Byte stream (valid/ready, transfer when both are high on a rising edge)
    logic [7:0]        in_byte;
    logic              in_valid;
    logic              in_ready;

    // Instruction-memory write port
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;

    modport slave (
        input  in_byte,
        input  in_valid,
        output in_ready,
        output im_we,
        output im_addr,
        output im_wdata
    );

    modport master (
        output in_byte,
        output in_valid,
        input  in_ready,
        input  im_we,
        input  im_addr,
        input  im_wdata
    );
endinterface

// File: rtl/inst_mem_loader.sv
// Boot-time instruction-memory loader for the single-cycle MIPS core.
// Assembles a big-endian byte stream into 32-bit words and writes them to
// consecutive instruction-memory addresses starting at 0. The CPU is held
// stalled until the whole program is in place. It is then released with a
// one-cycle reset pulse, so the PC restarts at word 0.
// All outputs are registered. in_ready depends only on the next state and
// never on in_valid.
module inst_mem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic                clk_CPU,
    input  logic                rst,
    input  logic                load_start,
    input  logic [ADDR_W:0]     load_len,
    inst_mem_loader_if.slave    bus,
    output logic                cpu_hold,
    output logic                cpu_rst,
    output logic                done,
    output logic                err,
    output logic [31:0]         checksum
);

    // Capacity in words, one bit wider than the address so it can be
    // compared directly against load_len.
    localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RECV  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // State and datapath registers
    logic [1:0]        state_q,    state_d;
    logic [ADDR_W:0]   len_q,      len_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
    logic [23:0]       asm_q,      asm_d;      // first three bytes of the current word
    logic              err_q,      err_d;
    logic [31:0]       checksum_q, checksum_d;

    // Registered outputs
    logic              in_ready_q, in_ready_d;
    logic              im_we_q,    im_we_d;
    logic [ADDR_W-1:0] im_addr_q,  im_addr_d;
    logic [31:0]       im_wdata_q, im_wdata_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              cpu_rst_q,  cpu_rst_d;
    logic              done_q,     done_d;

    // Combinational helpers
    logic              byte_fire;
    logic              last_word;
    logic              entering_done;

    assign byte_fire = bus.in_valid && in_ready_q;
    assign last_word = ({1'b0, word_cnt_q} == (len_q - (ADDR_W+1)'(1)));

    // Next-state, datapath and registered-output decode
    always_comb begin
        // NOTE: every variable written here gets a default first. A path that
        // leaves one unassigned would make synthesis infer a latch.
        state_d       = state_q;
        len_d         = len_q;
        byte_cnt_d    = byte_cnt_q;
        word_cnt_d    = word_cnt_q;
        asm_d         = asm_q;
        err_d         = err_q;
        checksum_d    = checksum_q;
        im_addr_d     = im_addr_q;
        im_wdata_d    = im_wdata_q;
        entering_done = 1'b0;

        case (state_q)
            // IDLE and DONE share the start decode. A new load can be
            // requested again once a program is running.
            S_IDLE, S_DONE: begin
                if (load_start) begin
                    len_d      = load_len;
                    checksum_d = '0;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                    err_d      = 1'b0;
                    if (load_len == '0) begin
                        state_d       = S_DONE;
                        entering_done = 1'b1;
                    end else if (load_len > CAPACITY) begin
                        // Too long to fit: flag it and do not touch memory.
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_RECV;
                    end
                end
            end

            // Shift bytes in MSB-first. The fourth byte completes the word,
            // which is presented on the write port during the next cycle.
            S_RECV: begin
                if (byte_fire) begin
                    asm_d = {asm_q[15:0], bus.in_byte};
                    if (byte_cnt_q == 2'd3) begin
                        byte_cnt_d = '0;
                        im_addr_d  = word_cnt_q;
                        im_wdata_d = {asm_q, bus.in_byte};
                        state_d    = S_WRITE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end

            // A single write cycle. The word being written folds into the
            // checksum on the edge that ends this cycle.
            S_WRITE: begin
                checksum_d = checksum_q ^ im_wdata_q;
                if (last_word) begin
                    state_d       = S_DONE;
                    entering_done = 1'b1;
                end else begin
                    word_cnt_d = word_cnt_q + ADDR_W'(1);
                    state_d    = S_RECV;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the state being entered and registered.
        // This keeps them glitch-free and independent of in_valid.
        in_ready_d = (state_d == S_RECV);
        im_we_d    = (state_d == S_WRITE);
        done_d     = (state_d == S_DONE);
        cpu_rst_d  = entering_done;
        // The CPU stays stalled through the reset-pulse cycle and runs after it.
        cpu_hold_d = (state_d != S_DONE) || entering_done;
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk_CPU or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments. Every flop then
        // samples its pre-edge value, whatever order the statements are in.
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            asm_q      <= '0;
            err_q      <= 1'b0;
            checksum_q <= '0;
            in_ready_q <= 1'b0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= '0;
            cpu_hold_q <= 1'b1;
            cpu_rst_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            asm_q      <= asm_d;
            err_q      <= err_d;
            checksum_q <= checksum_d;
            in_ready_q <= in_ready_d;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
            cpu_hold_q <= cpu_hold_d;
            cpu_rst_q  <= cpu_rst_d;
            done_q     <= done_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.im_we    = im_we_q;
    assign bus.im_addr  = im_addr_q;
    assign bus.im_wdata = im_wdata_q;
    assign cpu_hold     = cpu_hold_q;
    assign cpu_rst      = cpu_rst_q;
    assign done         = done_q;
    assign err          = err_q;
    assign checksum     = checksum_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader. It applies table-driven loads,
// then hand-written sequences for the length-error, zero-length,
// full-capacity and mid-load-reset cases.
module tb_inst_mem_loader;

    localparam int ADDR_W = 8;

    logic              clk_CPU = 1'b0;
    logic              rst;
    logic              load_start;
    logic [ADDR_W:0]   load_len;
    logic              cpu_hold;
    logic              cpu_rst;
    logic              done;
    logic              err;
    logic [31:0]       checksum;

    inst_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    inst_mem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk_CPU    (clk_CPU),
        .rst        (rst),
        .load_start (load_start),
        .load_len   (load_len),
        .bus        (bus),
        .cpu_hold   (cpu_hold),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .err        (err),
        .checksum   (checksum)
    );

    always #5 clk_CPU = ~clk_CPU;

    int n_total = 0;
    int n_pass  = 0;

    // Monitor state, sampled on the falling edge (mid-cycle)
    logic [ADDR_W-1:0] wr_addr [$];
    logic [31:0]       wr_data [$];
    int                rst_pulses = 0;
    int                overlap    = 0;
    logic [31:0]       tx_words [$];

    always @(negedge clk_CPU) begin
        if (bus.im_we) begin
            wr_addr.push_back(bus.im_addr);
            wr_data.push_back(bus.im_wdata);
        end
        if (cpu_rst) rst_pulses++;
        if (bus.im_we && bus.in_ready) overlap++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_CPU);
        #1;
    endtask

    // Run one complete load of tx_words. Checks the write latency of every
    // word, the completion handshake, the captured writes and the checksum.
    task automatic run_load(input logic [ADDR_W:0] len, input bit toggle,
                            input logic [31:0] exp_ck, input string tag);
        int          nbytes;
        int          idx;
        int          guard;
        int          cyc;
        logic        rdy;
        logic        vld;
        logic [31:0] w;
        wr_addr.delete();
        wr_data.delete();
        rst_pulses = 0;
        overlap    = 0;
        load_len   = len;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        nbytes = tx_words.size() * 4;
        idx = 0; guard = 0; cyc = 0;
        while (idx < nbytes && guard < 5000) begin
            w            = tx_words[idx / 4];
            bus.in_byte  = w[31 - 8 * (idx % 4) -: 8];
            bus.in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            rdy = bus.in_ready;
            vld = bus.in_valid;
            tick();
            cyc++; guard++;
            if (rdy && vld) begin
                if (idx % 4 == 3) begin
                    check($sformatf("%s w%0d im_we", tag, idx / 4), {31'd0, bus.im_we}, 32'd1);
                    check($sformatf("%s w%0d im_addr", tag, idx / 4), {24'd0, bus.im_addr}, idx / 4);
                    check($sformatf("%s w%0d im_wdata", tag, idx / 4), bus.im_wdata, w);
                end
                idx++;
            end
        end
        check({tag, " bytes_accepted"}, idx, nbytes);
        guard = 0;
        while (!done && guard < 20) begin
            tick();
            guard++;
        end
        check({tag, " done"}, {31'd0, done}, 32'd1);
        check({tag, " cpu_rst_first"}, {31'd0, cpu_rst}, 32'd1);
        check({tag, " cpu_hold_first"}, {31'd0, cpu_hold}, 32'd1);
        tick();
        check({tag, " cpu_rst_after"}, {31'd0, cpu_rst}, 32'd0);
        check({tag, " cpu_hold_after"}, {31'd0, cpu_hold}, 32'd0);
        check({tag, " done_after"}, {31'd0, done}, 32'd1);
        check({tag, " checksum"}, checksum, exp_ck);
        check({tag, " err"}, {31'd0, err}, 32'd0);
        check({tag, " write_count"}, wr_addr.size(), tx_words.size());
        for (int i = 0; i < wr_addr.size() && i < tx_words.size(); i++) begin
            check($sformatf("%s wr%0d addr", tag, i), {24'd0, wr_addr[i]}, i);
            check($sformatf("%s wr%0d data", tag, i), wr_data[i], tx_words[i]);
        end
        check({tag, " rst_pulses"}, rst_pulses, 1);
        check({tag, " we_with_ready"}, overlap, 0);
        bus.in_valid = 1'b0;
    endtask

    typedef struct {
        logic [ADDR_W:0] len;
        bit              toggle;
        int              nwords;
        logic [31:0]     w0;
        logic [31:0]     w1;
        logic [31:0]     exp_ck;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ck;
        int          got;
        int          guard;
        logic        rdy;

        vecs[0] = '{len: 9'd1, toggle: 1'b0, nwords: 1, w0: 32'hDEADBEEF, w1: 32'h0,        exp_ck: 32'hDEADBEEF};
        vecs[1] = '{len: 9'd2, toggle: 1'b0, nwords: 2, w0: 32'h20080005, w1: 32'h0000000C, exp_ck: 32'h20080009};
        vecs[2] = '{len: 9'd2, toggle: 1'b1, nwords: 2, w0: 32'h20080005, w1: 32'h0000000C, exp_ck: 32'h20080009};
        vecs[3] = '{len: 9'd2, toggle: 1'b0, nwords: 2, w0: 32'h12345678, w1: 32'h87654321, exp_ck: 32'h95511559};

        // Reset state, with in_valid held high
        rst = 1'b1; load_start = 1'b0; load_len = '0;
        bus.in_byte = 8'hFF; bus.in_valid = 1'b1;
        tick(); tick();
        check("rst cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst im_we", {31'd0, bus.im_we}, 32'd0);
        check("rst checksum", checksum, 32'd0);
        check("rst err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        tick(); tick(); tick();
        check("idle in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("idle im_we", {31'd0, bus.im_we}, 32'd0);
        check("idle cpu_hold", {31'd0, cpu_hold}, 32'd1);
        bus.in_valid = 1'b0;

        // Table-driven loads (all but the first start from DONE)
        for (int i = 0; i < 4; i++) begin
            tx_words.delete();
            tx_words.push_back(vecs[i].w0);
            if (vecs[i].nwords > 1) tx_words.push_back(vecs[i].w1);
            run_load(vecs[i].len, vecs[i].toggle, vecs[i].exp_ck, $sformatf("vec%0d", i));
        end

        // Over-capacity length from DONE: error flag set, back to IDLE
        load_len = 9'd257; load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("ovf err", {31'd0, err}, 32'd1);
        check("ovf done", {31'd0, done}, 32'd0);
        check("ovf cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("ovf in_ready", {31'd0, bus.in_ready}, 32'd0);
        bus.in_valid = 1'b1;
        tick(); tick();
        check("ovf stays idle", {31'd0, bus.in_ready}, 32'd0);
        check("ovf err sticky", {31'd0, err}, 32'd1);
        bus.in_valid = 1'b0;

        // Zero-length load from IDLE clears err and completes at once
        tx_words.delete();
        run_load(9'd0, 1'b0, 32'h0, "len0");

        // Full-capacity load: addresses 0..255
        tx_words.delete();
        ck = '0;
        for (int i = 0; i < 256; i++) begin
            tx_words.push_back((32'h9E3779B9 * i) ^ {24'h5A5A00, i[7:0]});
            ck = ck ^ tx_words[i];
        end
        run_load(9'd256, 1'b0, ck, "full");

        // Asynchronous reset after 6 bytes of a 3-word load
        load_len = 9'd3; load_start = 1'b1;
        tick();
        load_start = 1'b0;
        got = 0; guard = 0;
        bus.in_valid = 1'b1;
        while (got < 6 && guard < 100) begin
            bus.in_byte = 8'(got + 1);
            rdy = bus.in_ready;
            tick();
            guard++;
            if (rdy) got++;
        end
        check("mid bytes_sent", got, 6);
        check("mid checksum_before", checksum, 32'h01020304);
        #3;
        rst = 1'b1;
        load_start = 1'b1;
        load_len = 9'd1;
        #1;
        check("async in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("async im_we", {31'd0, bus.im_we}, 32'd0);
        check("async im_addr", {24'd0, bus.im_addr}, 32'd0);
        check("async im_wdata", bus.im_wdata, 32'd0);
        check("async cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("async cpu_rst", {31'd0, cpu_rst}, 32'd0);
        check("async done", {31'd0, done}, 32'd0);
        check("async err", {31'd0, err}, 32'd0);
        check("async checksum", checksum, 32'd0);
        tick();
        check("rst beats start", {31'd0, bus.in_ready}, 32'd0);
        load_start = 1'b0;
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b0;
        tick();
        tx_words.delete();
        tx_words.push_back(32'hAABBCCDD);
        run_load(9'd1, 1'b0, 32'hAABBCCDD, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
